// File: rtl/mux_arbiter_if.sv
// Handshake/bus bundle between the two requesters and the mux arbiter.
// master drives requests and data; slave returns grants and muxed output.
interface mux_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req_c;
  logic [WIDTH-1:0] c;
  logic             req_d;
  logic [WIDTH-1:0] d;
  logic             gnt_c;
  logic             gnt_d;
  logic             sl;
  logic [WIDTH-1:0] o;
  logic             o_vld;

  modport master (
    output req_c, c, req_d, d,
    input  gnt_c, gnt_d, sl, o, o_vld
  );

  modport slave (
    input  req_c, c, req_d, d,
    output gnt_c, gnt_d, sl, o, o_vld
  );
endinterface

// File: rtl/mux_arbiter.sv
// Two-leg registered mux with round-robin arbitration between requesters C and D.
// Define MUX_ARB_FAIRNESS_EN to cap each grant at BURST transfers while the other side waits.
module mux_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_d;
  logic             last_d_nxt;
  logic             sl_nxt;
  logic             xfer_c;
  logic             xfer_d;

  logic             gnt_c_q;
  logic             gnt_d_q;
  logic             sl_q;
  logic             o_vld_q;
  logic [WIDTH-1:0] o_q;

`ifdef MUX_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = 4;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             burst_end;
`endif

  // Legal burst length is 1..15 (fits the 4-bit counter).
  always_comb begin : burst_range_chk
    assert (BURST >= 1 && BURST <= 15);
  end

  assign xfer_c = (state == GNT_C) && bus.req_c;
  assign xfer_d = (state == GNT_D) && bus.req_d;

`ifdef MUX_ARB_FAIRNESS_EN
  assign burst_end = (cnt == CNT_W'(BURST - 1));
`endif

  // Next-state, pointer, select and burst counter
  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    sl_nxt     = sl_q;
`ifdef MUX_ARB_FAIRNESS_EN
    cnt_nxt    = cnt;
`endif

    unique case (state)
      IDLE: begin
        if (bus.req_c && bus.req_d) begin
          state_nxt = last_d ? GNT_C : GNT_D;
        end else if (bus.req_c) begin
          state_nxt = GNT_C;
        end else if (bus.req_d) begin
          state_nxt = GNT_D;
        end
      end
      GNT_C: begin
        if (!bus.req_c) begin
          state_nxt = bus.req_d ? GNT_D : IDLE;
        end
`ifdef MUX_ARB_FAIRNESS_EN
        else if (burst_end && bus.req_d) begin
          state_nxt = GNT_D;
        end
`endif
      end
      GNT_D: begin
        if (!bus.req_d) begin
          state_nxt = bus.req_c ? GNT_C : IDLE;
        end
`ifdef MUX_ARB_FAIRNESS_EN
        else if (burst_end && bus.req_c) begin
          state_nxt = GNT_C;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase

    // Pointer remembers whoever was granted most recently; IDLE keeps it
    if (state_nxt != state) begin
      if (state_nxt == GNT_C) begin
        last_d_nxt = 1'b0;
      end else if (state_nxt == GNT_D) begin
        last_d_nxt = 1'b1;
      end
    end

    if (state_nxt == GNT_C) begin
      sl_nxt = 1'b1;
    end else if (state_nxt == GNT_D) begin
      sl_nxt = 1'b0;
    end

`ifdef MUX_ARB_FAIRNESS_EN
    // Count restarts on every grant change and after a full burst that kept the grant
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (xfer_c || xfer_d) begin
      cnt_nxt = burst_end ? '0 : cnt + CNT_W'(1);
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

`ifdef MUX_ARB_FAIRNESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`endif

  // Registered grants, select and muxed data
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_c_q <= 1'b0;
      gnt_d_q <= 1'b0;
      sl_q    <= 1'b0;
      o_vld_q <= 1'b0;
      o_q     <= '0;
    end else begin
      gnt_c_q <= (state_nxt == GNT_C);
      gnt_d_q <= (state_nxt == GNT_D);
      sl_q    <= sl_nxt;
      o_vld_q <= xfer_c || xfer_d;
      if (xfer_c) begin
        o_q <= bus.c;
      end else if (xfer_d) begin
        o_q <= bus.d;
      end
    end
  end

  assign bus.gnt_c = gnt_c_q;
  assign bus.gnt_d = gnt_d_q;
  assign bus.sl    = sl_q;
  assign bus.o_vld = o_vld_q;
  assign bus.o     = o_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: expected {gnt_c,gnt_d,sl,o_vld,o} queued per cycle, compared after each edge.
module tb_mux_arbiter;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned BURST = 4;
`ifdef MUX_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs;
  logic [7:0] exp_v;

  mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  task automatic drive(input logic r, input logic rc, input logic [3:0] cv,
                       input logic rd, input logic [3:0] dv);
    rst = r; bus.req_c = rc; bus.c = cv; bus.req_d = rd; bus.d = dv;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive((i < 3), 1'b0, 4'hF, 1'b0, 4'hF);
      exp_q.push_back(8'h00);
      @(posedge clk); #1;
      obs = {bus.gnt_c, bus.gnt_d, bus.sl, bus.o_vld, bus.o};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  // Single requester C for 3 edges then release
  task automatic test_single_c();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, (i <= 3), 4'hA, 1'b0, 4'h5);
      case (i)
        1:       exp_q.push_back({4'b1010, 4'h0});
        2, 3:    exp_q.push_back({4'b1011, 4'hA});
        default: exp_q.push_back({4'b0010, 4'hA});
      endcase
      @(posedge clk); #1;
      obs = {bus.gnt_c, bus.gnt_d, bus.sl, bus.o_vld, bus.o};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL single_c edge=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  // Tie from reset goes to C; C release hands straight to D
  task automatic test_tie_switch();
    for (int i = 0; i <= 5; i++) begin
      case (i)
        0: begin drive(1'b1, 1'b0, 4'h5, 1'b0, 4'h6); exp_q.push_back({4'b0000, 4'h0}); end
        1: begin drive(1'b0, 1'b1, 4'h5, 1'b1, 4'h6); exp_q.push_back({4'b1010, 4'h0}); end
        2: begin drive(1'b0, 1'b1, 4'h5, 1'b1, 4'h6); exp_q.push_back({4'b1011, 4'h5}); end
        3: begin drive(1'b0, 1'b0, 4'h5, 1'b1, 4'h6); exp_q.push_back({4'b0100, 4'h5}); end
        4: begin drive(1'b0, 1'b0, 4'h5, 1'b1, 4'h6); exp_q.push_back({4'b0101, 4'h6}); end
        default: begin drive(1'b0, 1'b0, 4'h5, 1'b0, 4'h6); exp_q.push_back({4'b0000, 4'h6}); end
      endcase
      @(posedge clk); #1;
      obs = {bus.gnt_c, bus.gnt_d, bus.sl, bus.o_vld, bus.o};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL tie_switch step=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  // Both requesting continuously: alternate every BURST transfers only when fair
  task automatic test_burst();
    logic srv_c;
    logic xc;
    drive(1'b1, 1'b0, 4'h3, 1'b0, 4'hC);
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b1, 4'h3, 1'b1, 4'hC);
      srv_c = FAIR ? ((((k - 1) / BURST) % 2) == 0) : 1'b1;
      if (k == 1) begin
        exp_q.push_back({srv_c, ~srv_c, srv_c, 1'b0, 4'h0});
      end else begin
        xc = FAIR ? ((((k - 2) / BURST) % 2) == 0) : 1'b1;
        exp_q.push_back({srv_c, ~srv_c, srv_c, 1'b1, (xc ? 4'h3 : 4'hC)});
      end
      @(posedge clk); #1;
      obs = {bus.gnt_c, bus.gnt_d, bus.sl, bus.o_vld, bus.o};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL burst edge=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  // Lone requester keeps the grant past BURST with fresh data every edge
  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b1, 4'(k + 2), 1'b0, 4'hE);
      if (k == 1) exp_q.push_back({4'b1010, 4'h0});
      else        exp_q.push_back({4'b1011, 4'(k + 2)});
      @(posedge clk); #1;
      obs = {bus.gnt_c, bus.gnt_d, bus.sl, bus.o_vld, bus.o};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL back_to_back edge=%0d got=%b exp=%b", k, obs, exp_v);
      end
    end
  endtask

  // Reset pulse while D holds the grant mid-burst
  task automatic test_reset_mid();
    for (int i = 0; i <= 5; i++) begin
      case (i)
        0: begin drive(1'b1, 1'b0, 4'h7, 1'b0, 4'h9); exp_q.push_back({4'b0000, 4'h0}); end
        1: begin drive(1'b0, 1'b0, 4'h7, 1'b1, 4'h9); exp_q.push_back({4'b0100, 4'h0}); end
        2: begin drive(1'b0, 1'b0, 4'h7, 1'b1, 4'h9); exp_q.push_back({4'b0101, 4'h9}); end
        3: begin drive(1'b1, 1'b1, 4'h7, 1'b1, 4'h9); exp_q.push_back({4'b0000, 4'h0}); end
        4: begin drive(1'b0, 1'b1, 4'h7, 1'b1, 4'h9); exp_q.push_back({4'b1010, 4'h0}); end
        default: begin drive(1'b0, 1'b1, 4'h7, 1'b1, 4'h9); exp_q.push_back({4'b1011, 4'h7}); end
      endcase
      @(posedge clk); #1;
      obs = {bus.gnt_c, bus.gnt_d, bus.sl, bus.o_vld, bus.o};
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_mid step=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    test_reset();
    test_single_c();
    test_tie_switch();
    test_burst();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, datapath width of each mux leg.
REQ-002 The module SHALL have parameter BURST, default 4, the maximum consecutive transfers per grant when fairness is enabled; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_c  input  1  requester C (mux c leg) wants transfers.
REQ-006 c  input  WIDTH  requester C data.
REQ-007 req_d  input  1  requester D (mux d leg) wants transfers.
REQ-008 d  input  WIDTH  requester D data.
REQ-009 gnt_c  output  1  registered grant to C.
REQ-010 gnt_d  output  1  registered grant to D.
REQ-011 sl  output  1  registered mux select; 1 selects c, 0 selects d.
REQ-012 o  output  WIDTH  registered muxed data.
REQ-013 o_vld  output  1  o carries a transfer made on the previous edge.

Function
REQ-014 The FSM SHALL have states IDLE, GNT_C and GNT_D; gnt_c=1 only in GNT_C, gnt_d=1 only in GNT_D, never both.
REQ-015 sl SHALL be 1 in GNT_C, 0 in GNT_D, and SHALL hold its last value in IDLE.
REQ-016 A transfer SHALL occur on an edge where gnt_x=1 and req_x=1: o <= x data, o_vld <= 1; on every other edge o_vld <= 0 and o holds.
REQ-017 IDLE: only req_c -> GNT_C; only req_d -> GNT_D; both -> the requester not served last (pointer last_d); neither -> stay.
REQ-018 Latency: req_x asserted before edge N from IDLE -> gnt_x high after N; first transfer at edge N+1; o/o_vld visible after N+1.
REQ-019 GNT_x with req_x=0 on an edge: no transfer; go to GNT_other if req_other=1, else IDLE; burst count cleared.
REQ-020 Each transfer SHALL increment a burst counter; the counter SHALL clear on any state change.
REQ-021 The pointer SHALL record the requester granted most recently; update on entry to GNT_C or GNT_D.
REQ-022 Switching between GNT_C and GNT_D SHALL be direct, with no IDLE cycle; the edge performing the final transfer of one leg also moves grant.
REQ-023 Requests are level-sensitive; a requester SHALL NOT be required to drop req between bursts.

Reset
REQ-024 rst=1 on an edge SHALL force: state IDLE, gnt_c=0, gnt_d=0, sl=0, o=0, o_vld=0, burst count 0, pointer = D-served-last (C wins first tie).
REQ-025 Reset mid-transfer SHALL abandon the grant; no transfer occurs on the reset edge; rst has priority over all other inputs.

Configuration
REQ-026 Macro MUX_ARB_FAIRNESS_EN SHALL select burst limiting.
REQ-027 With MUX_ARB_FAIRNESS_EN defined: when the BURST-th transfer of a grant occurs and req_other=1, grant SHALL move to the other requester on that edge; if req_other=0, grant SHALL stay and the count SHALL clear.
REQ-028 Without MUX_ARB_FAIRNESS_EN: no burst counter; grant SHALL be held until req_x drops (REQ-019); BURST is ignored.

Verification
REQ-029 Reset, req_c=req_d=0 -> gnt_c=gnt_d=0, sl=0, o=4'h0, o_vld=0 every cycle.
REQ-030 From reset, req_c=1, c=4'hA for 3 edges then 0 -> gnt_c high 1 edge after req; o=4'hA with o_vld=1 on next 2 edges (transfers at edges 2..3); gnt_c low after req drops, state IDLE.
REQ-031 From IDLE, req_c=req_d=1 same edge -> gnt_c wins (pointer reset); after C releases with D still requesting, gnt_d=1 and sl=0 on the very next edge, no IDLE cycle.
REQ-032 FAIRNESS_EN, BURST=4, req_c=req_d=1 constant, c=4'h3, d=4'hC -> o pattern 3,3,3,3,C,C,C,C,3... with o_vld continuously 1 after first transfer; sl toggles every 4 transfers.
REQ-033 Fairness disabled, same stimulus as REQ-032 -> o=4'h3 indefinitely, gnt_d never asserts.
REQ-034 rst pulsed 1 cycle during GNT_D mid-burst -> next edge all outputs at reset values; with both requests held, C granted first after reset releases.
